// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the encoder and the frame decoder,
// so both directions of the link work from one code table.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    // Active-low segment codes: bit7 = DP (kept off, i.e. 1), bits6:0 = g..a.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One decoded beat as held in the stage-1 register.
    typedef struct packed {
        logic [DIGIT_W-1:0] digit;
        logic               is_digit;
        logic               is_blank;
        logic               is_illegal;
        logic               last;
    } beat_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational classifier: segment code -> decimal digit plus class flags.
// Exactly one of is_digit / is_blank / is_illegal is set for every code.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [7:0]         seg,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_digit,
    output logic               is_blank,
    output logic               is_illegal
);

    // Table lookup of the ten digit patterns and the blank pattern.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        digit      = '0;
        is_digit   = 1'b1;
        is_blank   = 1'b0;
        is_illegal = 1'b0;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            // Anything else, including every code with the DP segment lit.
            default: begin
                is_digit   = 1'b0;
                is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Receive side of the 7-segment link: decodes a stream of segment codes
// (most significant digit first) into one binary value per frame.
// Pipeline: stage-1 decode register -> accumulator (emits a finished-frame
// register) -> held output register. A held, unaccepted result freezes all
// stages and drops in_ready.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NDIGITS = 3,
    parameter int OUT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_seg,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic [1:0]       out_ndigits,
    output logic             out_error
);

    logic stall;

    // Decoder outputs for the beat currently on the input.
    logic [DIGIT_W-1:0] dec_digit;
    logic               dec_is_digit;
    logic               dec_is_blank;
    logic               dec_is_illegal;

    // Stage 1.
    logic  s1_valid;
    beat_t s1;

    // Accumulator state for the frame in progress.
    logic [OUT_W-1:0] acc;
    logic [1:0]       cnt;
    logic             err;

    // Accumulator state after folding in the stage-1 entry.
    logic [OUT_W-1:0] acc_upd;
    logic [1:0]       cnt_upd;
    logic             err_upd;

    // Finished frame waiting to move into the output register.
    logic             frm_valid;
    logic [OUT_W-1:0] frm_value;
    logic [1:0]       frm_ndigits;
    logic             frm_error;

    // The only reason to stop is a result the consumer has not taken yet;
    // in_ready never looks at in_valid.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    seg7_pattern_decode u_decode (
        .seg        (in_seg),
        .digit      (dec_digit),
        .is_digit   (dec_is_digit),
        .is_blank   (dec_is_blank),
        .is_illegal (dec_is_illegal)
    );

    // Stage 1: capture the decoded beat whenever one is accepted.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every stage
        // samples the pre-edge value of the stage before it.
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1.digit      <= dec_digit;
                s1.is_digit   <= dec_is_digit;
                s1.is_blank   <= dec_is_blank;
                s1.is_illegal <= dec_is_illegal;
                s1.last       <= in_last;
            end
        end
    end

    // Fold the stage-1 entry into the running frame: digits shift in while
    // there is room, surplus digits and illegal codes only raise the error.
    always_comb begin
        acc_upd = acc;
        cnt_upd = cnt;
        err_upd = err;
        if (s1_valid) begin
            if (s1.is_digit) begin
                if (cnt < 2'(NDIGITS)) begin
                    acc_upd = OUT_W'(acc * OUT_W'(10)) + OUT_W'(s1.digit);
                    cnt_upd = cnt + 2'd1;
                end else begin
                    err_upd = 1'b1;
                end
            end else if (s1.is_illegal) begin
                err_upd = 1'b1;
            end
        end
    end

    // Stage 2: advance the accumulator; on the last beat hand the frame off
    // and start the next one from zero in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            frm_valid   <= 1'b0;
            frm_value   <= '0;
            frm_ndigits <= '0;
            frm_error   <= 1'b0;
        end else if (!stall) begin
            frm_valid <= s1_valid & s1.last;
            if (s1_valid && s1.last) begin
                frm_value   <= acc_upd;
                frm_ndigits <= cnt_upd;
                frm_error   <= err_upd;
                acc         <= '0;
                cnt         <= '0;
                err         <= 1'b0;
            end else begin
                acc <= acc_upd;
                cnt <= cnt_upd;
                err <= err_upd;
            end
        end
    end

    // Output register: load a finished frame, or retire the current result
    // once taken. Frozen while the consumer holds off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_value   <= '0;
            out_ndigits <= '0;
            out_error   <= 1'b0;
        end else if (!stall) begin
            if (frm_valid) begin
                out_valid   <= 1'b1;
                out_value   <= frm_value;
                out_ndigits <= frm_ndigits;
                out_error   <= frm_error;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: the stimulus process pushes the
// hand-computed result of each frame, a monitor pops and compares on every
// output handshake.
module tb_seg7_frame_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_seg;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_value;
    logic [1:0] out_ndigits;
    logic       out_error;

    typedef struct {
        logic [9:0] value;
        logic [1:0] nd;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    seg7_frame_decoder #(
        .NDIGITS (3),
        .OUT_W   (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_seg      (in_seg),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_ndigits (out_ndigits),
        .out_error   (out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [9:0] v, input logic [1:0] nd, input logic e);
        exp_t x;
        x.value = v;
        x.nd    = nd;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [7:0] seg, input logic last);
        int waits = 0;
        in_valid = 1'b1;
        in_seg   = seg;
        in_last  = last;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_beat_timeout: in_ready stuck at 0 for seg %h", seg);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: sample well clear of both edges; a handshake seen here
    // completes at the next rising edge.
    logic       prev_stall = 1'b0;
    logic [9:0] prev_value = '0;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_value", out_value, prev_value);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got value %0d with empty scoreboard", out_value);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("out_value",   out_value,   x.value);
                    check("out_ndigits", out_ndigits, x.nd);
                    check("out_error",   out_error,   x.err);
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_value = out_value;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_seg    = 8'hFF;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_value",   out_value,   0);
        check("rst_out_ndigits", out_ndigits, 0);
        check("rst_out_error",   out_error,   0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Basic frame with latency check: result visible after edge N+2.
        expect_frame(10'd231, 2'd3, 1'b0);
        send_beat(8'hA4, 1'b0);
        send_beat(8'hB0, 1'b0);
        send_beat(8'hF9, 1'b1);
        check("lat_after_n",  out_valid, 0);
        @(negedge clk);
        check("lat_after_n1", out_valid, 0);
        @(negedge clk);
        check("lat_after_n2", out_valid, 1);
        @(negedge clk);

        // Back-to-back frames: blanks, empty, illegal, DP-lit, overflow.
        expect_frame(10'd5, 2'd1, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'h92, 1'b1);
        expect_frame(10'd0, 2'd0, 1'b0);
        send_beat(8'hFF, 1'b1);
        expect_frame(10'd10, 2'd2, 1'b1);
        send_beat(8'hF9, 1'b0);
        send_beat(8'h00, 1'b0);
        send_beat(8'hC0, 1'b1);
        expect_frame(10'd0, 2'd0, 1'b1);
        send_beat(8'h79, 1'b1);
        expect_frame(10'd123, 2'd3, 1'b1);
        send_beat(8'hF9, 1'b0);
        send_beat(8'hA4, 1'b0);
        send_beat(8'hB0, 1'b0);
        send_beat(8'h99, 1'b1);
        expect_frame(10'd987, 2'd3, 1'b0);
        send_beat(8'h90, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'h80, 1'b0);
        send_beat(8'hF8, 1'b1);
        repeat (4) @(negedge clk);

        // Backpressure: two frames queue up behind a held result.
        out_ready = 1'b0;
        expect_frame(10'd0, 2'd1, 1'b0);
        expect_frame(10'd9, 2'd1, 1'b0);
        send_beat(8'hC0, 1'b1);
        send_beat(8'h90, 1'b1);
        @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready",  in_ready,  0);
        check("bp_value",     out_value, 0);
        repeat (3) @(negedge clk);
        check("bp_value_later", out_value, 0);
        check("bp_in_ready_later", in_ready, 0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Reset mid-frame with a held result: both are discarded.
        out_ready = 1'b0;
        send_beat(8'h99, 1'b1);
        send_beat(8'hF9, 1'b0);
        send_beat(8'hA4, 1'b0);
        @(negedge clk);
        check("prerst_held", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_value", out_value, 0);
        @(negedge clk);
        check("rst_held_valid", out_valid, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        expect_frame(10'd3, 2'd1, 1'b0);
        send_beat(8'hB0, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seg7_frame_decoder.md
# seg7_frame_decoder

Receive-side counterpart of the binary-to-7-segment encoder. Accepts a stream of 8-bit active-low segment codes (one digit per beat, most significant digit first) over a valid/ready handshake. Decodes each code back to a decimal digit and accumulates a frame into a binary value. Each completed frame is presented on a held output register with its own valid/ready handshake. It sits between a segment-pattern source (loopback of display drivers, or switch-entered patterns) and datapath logic that consumes binary operands.

## Interface
- NDIGITS, 3: maximum decimal digits per frame; 10^NDIGITS-1 must fit in OUT_W bits
- OUT_W, 10: width of the decoded binary value
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_seg/in_last valid this cycle
- in_ready  out  1  decoder accepts a beat when in_valid & in_ready
- in_seg  in  8  segment code, active-low, bit7 = DP, bits6:0 = g..a
- in_last  in  1  marks final beat of a frame
- out_valid  out  1  frame result held on out_* ports
- out_ready  in  1  consumer takes the result when out_valid & out_ready
- out_value  out  OUT_W  accumulated binary value of the frame
- out_ndigits  out  2  number of digits accumulated (0..NDIGITS)
- out_error  out  1  frame contained an illegal code or too many digits

## Operation
- Code classes, with DP bit7 required to be 1:
  - digit codes: C0,F9,A4,B0,99,92,82,F8,80,90 map to 0..9
  - blank: FF
  - illegal: every other value, including any code with bit7=0
- Stage 1 (decode register) captures the digit value, class flags and in_last on every accepted beat.
- Stage 2 (accumulator) processes the stage-1 entry as follows:
  - digit with count < NDIGITS: acc <= acc*10 + d; count++.
  - digit with count == NDIGITS: acc and count unchanged; frame error set (overflow).
  - blank: no change to acc, count or error; blanks may appear anywhere in the frame.
  - illegal: frame error set; acc and count unchanged.
  - Error is sticky until the end of the frame.
- Frame completion when the stage-1 entry has last=1:
  - out_value/out_ndigits/out_error load the acc/count/error values after including that entry.
  - out_valid is set.
  - acc, count and error clear to 0 in the same cycle.
- Empty frame (only blanks, last set) gives value 0, ndigits 0, error 0.
- Output register holds stable while out_valid & ~out_ready.
- Global stall = out_valid & ~out_ready. Stall holds stage 1 and stage 2 frozen and drives in_ready = 0. in_ready = ~stall otherwise.
- Reset: everything clears immediately, including any partial frame, which is discarded.
  - Reset values: in_ready 1 (after deassertion), out_valid 0, out_value 0, out_ndigits 0, out_error 0.
  - Stage-1 valid is 0.

## Timing
- Latency: last beat accepted at edge N gives out_valid high after edge N+2.
- Throughput: one beat per cycle when there is no stall. Back-to-back frames are supported with no bubble.
- When out_valid & out_ready and a new frame completes in the same cycle, the output reloads with the new frame and out_valid stays 1.
- in_ready is combinational from out_valid/out_ready only, with no path from in_valid.
- in_seg/in_last are ignored when in_valid=0 or in_ready=0.
- Assertion of rst mid-frame or mid-stall: out_valid drops asynchronously. The first frame after deassertion starts clean.

## Structure
- Shared package seg7_pkg:
  - SEG_0..SEG_9 and SEG_BLANK constants, shared with the encoder so both directions use one table.
  - DIGIT_W = 4.
- Sub-module seg7_pattern_decode: combinational code → {digit[3:0], is_digit, is_blank, is_illegal}. It is instantiated once in stage 1.
- Top holds the stage-1 register, accumulator/counter, output register and stall logic.

## Test plan
- Basic frame: A4,B0,F9(last) with out_ready=1 gives out_value=231, ndigits=2'd3, error=0, two cycles after the last beat.
- Blanks: FF,FF,92(last) gives value=5, ndigits=1, error=0. A single FF(last) gives value=0, ndigits=0.
- Illegal code: F9,00,C0(last) gives value=10, ndigits=2, error=1. Bit7=0 code 79 is also flagged as error.
- Overflow: F9,A4,B0,99(last) gives value=123, ndigits=3, error=1.
- Backpressure: with out_ready=0 after frame C0(last), then frame 90(last):
  - in_ready falls while the first result is held; out_value stays 0.
  - Raising out_ready gives 0, then 9 on the next handshake, with no beat lost.
- Reset mid-frame: send F9,A4, pulse rst, then B0(last). Result must be value=3, ndigits=1. out_valid must be 0 during rst.
